// File: rtl/core_sequencer.sv
// Purpose : multi-cycle FETCH -> EXEC -> (MEM) sequencer with trap entry, debug halt and retire counting.
// Latency : one state per stage handshake; retire/reg_d_en are combinational, retire_count updates the next cycle.
// Backpress: each stage holds its valid until its ready arrives; optional stall timeout diverts to TRAP.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   {fetch,exec,mem,trap}_stage_valid  stage active (decoded from state)
//   {fetch,exec,mem,trap}_stage_ready  stage completes this cycle
//   mem_op, rd_we, trap_req            instruction attributes, only sampled on a handshake
//   halt_req / halted                  debug halt request (taken at instruction boundary) / in HALT
//   reg_d_en, retire, retire_count     register write enable, retire pulse, retired-instruction count
//   timeout                            stall-limit pulse (tied 0 unless CORE_SEQ_TIMEOUT_EN is defined)
//
// Build option: define CORE_SEQ_TIMEOUT_EN to add the per-stage stall counter.

module core_sequencer #(
    parameter int unsigned RETIRE_W       = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                fetch_stage_valid,
    input  logic                fetch_stage_ready,
    output logic                exec_stage_valid,
    input  logic                exec_stage_ready,
    output logic                mem_stage_valid,
    input  logic                mem_stage_ready,
    input  logic                mem_op,
    input  logic                rd_we,
    input  logic                trap_req,
    output logic                trap_stage_valid,
    input  logic                trap_stage_ready,
    input  logic                halt_req,
    output logic                halted,
    output logic                reg_d_en,
    output logic                retire,
    output logic [RETIRE_W-1:0] retire_count,
    output logic                timeout
);

    if (RETIRE_W < 1) begin : g_bad_retire_w
        $error("core_sequencer: RETIRE_W must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("core_sequencer: TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_TRAP  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [RETIRE_W-1:0] CNT_ONE = 1;

    state_t              state_q;
    state_t              state_d;
    state_t              boundary_st;
    logic                fetch_hs;
    logic                exec_hs;
    logic                mem_hs;
    logic                trap_hs;
    logic                stall_to;
    logic [RETIRE_W-1:0] retire_count_q;

    // Stage valids come straight off the state register so reset drops them
    // without waiting for a clock.
    assign fetch_stage_valid = (state_q == S_FETCH);
    assign exec_stage_valid  = (state_q == S_EXEC);
    assign mem_stage_valid   = (state_q == S_MEM);
    assign trap_stage_valid  = (state_q == S_TRAP);
    assign halted            = (state_q == S_HALT);

    assign fetch_hs = fetch_stage_valid & fetch_stage_ready;
    assign exec_hs  = exec_stage_valid  & exec_stage_ready;
    assign mem_hs   = mem_stage_valid   & mem_stage_ready;
    assign trap_hs  = trap_stage_valid  & trap_stage_ready;

    // A trap reported alongside the final handshake cancels retirement.
    assign retire       = (exec_hs & ~mem_op & ~trap_req) | (mem_hs & ~trap_req);
    assign reg_d_en     = retire & rd_we;
    assign retire_count = retire_count_q;

    // halt_req only matters where an instruction ends.
    assign boundary_st = halt_req ? S_HALT : S_FETCH;

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt_q;
    logic        stage_busy;

    // stall_cnt_q holds the number of cycles already spent in the current
    // stage, so the limit is hit during the TIMEOUT_CYCLES-th cycle.
    assign stage_busy = fetch_stage_valid | exec_stage_valid | mem_stage_valid;
    assign stall_to   = stage_busy & ~(fetch_hs | exec_hs | mem_hs)
                      & (stall_cnt_q == STALL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (state_d != state_q) begin
            stall_cnt_q <= '0;
        end else if (stage_busy) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
`else
    assign stall_to = 1'b0;
`endif

    assign timeout = stall_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (fetch_hs)      state_d = trap_req ? S_TRAP : S_EXEC;
                else if (stall_to) state_d = S_TRAP;
            end
            S_EXEC: begin
                if (exec_hs) begin
                    if (trap_req)    state_d = S_TRAP;
                    else if (mem_op) state_d = S_MEM;
                    else             state_d = boundary_st;
                end else if (stall_to) begin
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                if (mem_hs)        state_d = trap_req ? S_TRAP : boundary_st;
                else if (stall_to) state_d = S_TRAP;
            end
            S_TRAP: begin
                if (trap_hs) state_d = boundary_st;
            end
            S_HALT: begin
                if (!halt_req) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count_q <= '0;
        end else if (retire) begin
            retire_count_q <= retire_count_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_stage_valid, fetch_stage_ready;
    logic        exec_stage_valid, exec_stage_ready;
    logic        mem_stage_valid, mem_stage_ready;
    logic        mem_op, rd_we, trap_req;
    logic        trap_stage_valid, trap_stage_ready;
    logic        halt_req, halted, reg_d_en, retire, timeout;
    logic [63:0] retire_count;

    core_sequencer #(.RETIRE_W(64), .TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_stage_valid (fetch_stage_valid),
        .fetch_stage_ready (fetch_stage_ready),
        .exec_stage_valid  (exec_stage_valid),
        .exec_stage_ready  (exec_stage_ready),
        .mem_stage_valid   (mem_stage_valid),
        .mem_stage_ready   (mem_stage_ready),
        .mem_op            (mem_op),
        .rd_we             (rd_we),
        .trap_req          (trap_req),
        .trap_stage_valid  (trap_stage_valid),
        .trap_stage_ready  (trap_stage_ready),
        .halt_req          (halt_req),
        .halted            (halted),
        .reg_d_en          (reg_d_en),
        .retire            (retire),
        .retire_count      (retire_count),
        .timeout           (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        rd_we;
        logic [63:0] cnt;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vld(input string tag, input logic [3:0] exp);
        chk(tag, {60'd0, fetch_stage_valid, exec_stage_valid, mem_stage_valid, trap_stage_valid},
            {60'd0, exp});
    endtask

    task automatic expect_retire(input logic rw, input logic [63:0] c);
        exp_t e;
        e.rd_we = rw;
        e.cnt   = c;
        sb.push_back(e);
    endtask

    task automatic drive(input logic f, input logic e, input logic m, input logic t,
                         input logic mo, input logic rw, input logic tr, input logic h);
        fetch_stage_ready = f;
        exec_stage_ready  = e;
        mem_stage_ready   = m;
        trap_stage_ready  = t;
        mem_op            = mo;
        rd_we             = rw;
        trap_req          = tr;
        halt_req          = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Every retire pulse must match the oldest expected retirement.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1 && retire === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_retire", {63'd0, retire}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_reg_d_en", {63'd0, reg_d_en}, {63'd0, e.rd_we});
                chk("sb_count", retire_count, e.cnt);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_vld("rst_vld", 4'b0000);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_retire", {63'd0, retire}, 64'd0);
        chk("rst_reg_d_en", {63'd0, reg_d_en}, 64'd0);
        chk("rst_count", retire_count, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        #10 rst_n = 1'b1;
        #1 chk_vld("idle_vld", 4'b0000);
        tick();

        // ALU op, readies high
        drive(1, 0, 0, 0, 0, 0, 0, 0); smp(); chk_vld("alu_fetch", 4'b1000); tick();
        drive(0, 1, 0, 0, 0, 1, 0, 0); expect_retire(1'b1, 64'd0); smp();
        chk_vld("alu_exec", 4'b0100);
        chk("alu_retire", {63'd0, retire}, 64'd1);
        chk("alu_reg_d_en", {63'd0, reg_d_en}, 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); smp();
        chk_vld("alu_back", 4'b1000);
        chk("alu_count", retire_count, 64'd1);
        tick();

        // Store with mem ready delayed three cycles
        drive(1, 0, 0, 0, 0, 0, 0, 0); smp(); tick();
        drive(0, 1, 0, 0, 1, 0, 0, 0); smp();
        chk_vld("st_exec", 4'b0100);
        chk("st_exec_retire", {63'd0, retire}, 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 0); smp();
            chk_vld("st_mem_wait", 4'b0010);
            chk("st_mem_wait_retire", {63'd0, retire}, 64'd0);
            tick();
        end
        drive(0, 0, 1, 0, 1, 0, 0, 0); expect_retire(1'b0, 64'd1); smp();
        chk_vld("st_mem_hs", 4'b0010);
        chk("st_retire", {63'd0, retire}, 64'd1);
        chk("st_reg_d_en", {63'd0, reg_d_en}, 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); smp();
        chk_vld("st_back", 4'b1000);
        chk("st_count", retire_count, 64'd2);
        tick();

        // Trap on exec handshake beats mem_op
        drive(1, 0, 0, 0, 0, 0, 0, 0); smp(); tick();
        drive(0, 1, 0, 0, 1, 1, 1, 0); smp();
        chk("trap_retire", {63'd0, retire}, 64'd0);
        chk("trap_reg_d_en", {63'd0, reg_d_en}, 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); smp(); chk_vld("trap_wait", 4'b0001); tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0); smp(); chk_vld("trap_hs", 4'b0001); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); smp();
        chk_vld("trap_back", 4'b1000);
        chk("trap_count", retire_count, 64'd2);
        tick();

        // Halt requested mid-EXEC takes effect at the boundary
        drive(1, 0, 0, 0, 0, 0, 0, 0); smp(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); smp(); chk_vld("halt_exec_stay", 4'b0100); tick();
        drive(0, 1, 0, 0, 0, 1, 0, 1); expect_retire(1'b1, 64'd2); smp();
        chk("halt_retire", {63'd0, retire}, 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); smp();
        chk("halt_halted", {63'd0, halted}, 64'd1);
        chk_vld("halt_vld", 4'b0000);
        chk("halt_count", retire_count, 64'd3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); smp();
        chk("halt_release_cycle", {63'd0, halted}, 64'd1);
        tick();
        smp();
        chk("halt_exit", {63'd0, halted}, 64'd0);
        chk_vld("halt_exit_vld", 4'b1000);
        tick();

        // Reset asserted while in MEM
        drive(1, 0, 0, 0, 0, 0, 0, 0); smp(); tick();
        drive(0, 1, 0, 0, 1, 1, 0, 0); smp(); tick();
        drive(0, 0, 0, 0, 1, 1, 0, 0); smp(); chk_vld("rmid_mem", 4'b0010);
        #1 rst_n = 1'b0;
        drive(0, 0, 1, 0, 1, 1, 0, 0);
        #1;
        chk_vld("rmid_vld", 4'b0000);
        chk("rmid_count", retire_count, 64'd0);
        chk("rmid_retire", {63'd0, retire}, 64'd0);
        chk("rmid_reg_d_en", {63'd0, reg_d_en}, 64'd0);
        chk("rmid_halted", {63'd0, halted}, 64'd0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0); smp(); chk_vld("rmid_idle", 4'b0000); tick();
        smp(); chk_vld("rmid_fetch", 4'b1000); tick();

        // Counter wraps from all-ones
        drive(1, 0, 0, 0, 0, 0, 0, 0); smp(); tick();
        force dut.retire_count_q = '1;
        #1 release dut.retire_count_q;
        drive(0, 1, 0, 0, 0, 1, 0, 0); expect_retire(1'b1, '1); smp();
        chk("wrap_preload", retire_count, '1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); smp();
        chk("wrap_count", retire_count, 64'd0);
        tick();

`ifdef CORE_SEQ_TIMEOUT_EN
        // FETCH cycle 1 was the wrap check above; cycles 2..3 stall, 4 times out
        for (int i = 0; i < 2; i++) begin
            smp(); chk("to_quiet", {63'd0, timeout}, 64'd0); tick();
        end
        smp();
        chk("to_pulse", {63'd0, timeout}, 64'd1);
        chk("to_pulse_retire", {63'd0, retire}, 64'd0);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0); smp();
        chk_vld("to_trap", 4'b0001);
        chk("to_pulse_gone", {63'd0, timeout}, 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            smp(); chk("to_quiet2", {63'd0, timeout}, 64'd0); tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0); smp();
        chk("to_ready_wins", {63'd0, timeout}, 64'd0);
        tick();
`else
        // Without the timeout option a stage may stall indefinitely
        for (int i = 0; i < 6; i++) begin
            smp();
            chk("stall_no_timeout", {63'd0, timeout}, 64'd0);
            chk_vld("stall_fetch", 4'b1000);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0); smp(); tick();
`endif
        drive(0, 1, 0, 0, 0, 0, 0, 0); expect_retire(1'b0, 64'd0); smp();
        chk_vld("last_exec", 4'b0100);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); smp();
        chk("last_count", retire_count, 64'd1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
